hub75_bcm_ctrl: RTL and testbench



---
 rtl/hub75_bcm_ctrl_pkg.sv | 22 ++
 rtl/hub75_bcm_ctrl_frame_buf.sv | 48 ++++
 rtl/hub75_bcm_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_hub75_bcm_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/hub75_bcm_ctrl_pkg.sv
// Shared types for the HUB75 BCM panel driver: scan states, pixel field positions
// and the per-half colour bit bundle.
package hub75_bcm_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_PREP,
      ST_SHIFT,
      ST_LATCH,
      ST_DISPLAY
   } scan_state_e;

   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic r;
      logic g;
      logic b;
   } rgb_bits_t;

endpackage

// File: rtl/hub75_bcm_ctrl_frame_buf.sv
// Dual-bank frame store split into top/bottom halves. One write port and one
// registered read port that returns only the selected bit plane of each half.
module hub75_frame_buf
   import hub75_bcm_ctrl_pkg::*;
#(
   parameter int COLS          = 32,
   parameter int ROW_ADDR_BITS = 3,
   parameter int BPC           = 4,
   localparam int AW  = 1 + ROW_ADDR_BITS + $clog2(COLS),
   localparam int PLW = (BPC > 1) ? $clog2(BPC) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic                 w_half,
   input  logic [AW-1:0]        w_addr,
   input  logic [3*BPC-1:0]     w_data,
   input  logic                 re,
   input  logic [AW-1:0]        r_addr,
   input  logic [PLW-1:0]       r_plane,
   output rgb_bits_t [1:0]      rd_bits
);

   localparam int DEPTH = 1 << AW;

   for (genvar h = 0; h < 2; h++) begin : g_half
      logic [3*BPC-1:0] mem [DEPTH];
      logic [3*BPC-1:0] rd_word;
      rgb_bits_t        rd_q;

      // Contents survive reset; only the read register is cleared.
      always_ff @(posedge clk) begin
         if (we && (w_half == 1'(h))) mem[w_addr] <= w_data;
      end

      assign rd_word = mem[r_addr];

      always_ff @(posedge clk) begin
         if (reset)   rd_q <= '0;
         else if (re) rd_q <= {rd_word[2*BPC + int'(r_plane)],
                               rd_word[BPC + int'(r_plane)],
                               rd_word[int'(r_plane)]};
      end

      assign rd_bits[h] = rd_q;
   end

endmodule

// File: rtl/hub75_bcm_ctrl.sv
// HUB75 LED-matrix driver: Xillybus pixel writes into a double-buffered frame
// store, scanned out with binary-code-modulated colour depth and tear-free swaps.
module hub75_bcm_ctrl
   import hub75_bcm_ctrl_pkg::*;
#(
   parameter int COLS          = 32,
   parameter int ROW_ADDR_BITS = 3,
   parameter int BPC           = 4,
   parameter int CLK_DIV       = 2,
   parameter int BASE_ON       = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              data_in,
   input  logic                     data_in_en,
   output logic                     data_in_full,
   input  logic                     frame_restart,
   output logic                     led_clk,
   output logic                     lat,
   output logic                     oeb,
   output logic                     r1,
   output logic                     g1,
   output logic                     b1,
   output logic                     r2,
   output logic                     g2,
   output logic                     b2,
   output logic [ROW_ADDR_BITS-1:0] line
);

   localparam int CB  = $clog2(COLS);
   localparam int RB  = ROW_ADDR_BITS;
   localparam int PW  = 1 + RB + CB;
   localparam int PLW = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int CW  = $clog2((BASE_ON << (BPC - 1)) + CLK_DIV + 1);

   localparam logic [CW-1:0]  DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [PLW-1:0] PLANE_LAST = PLW'(BPC - 1);
   localparam logic [RB-1:0]  ROW_LAST   = '1;
   localparam logic [CB-1:0]  COL_LAST   = '1;

   // ---------------- write path ----------------
   logic [PW-1:0]    wr_ptr, wr_idx;
   logic             swap_pending, disp_bank, wr_ok, frame_end;
   logic [3*BPC-1:0] w_data;
   logic             unused_bits;

   assign wr_ok  = data_in_en & ~swap_pending;
   assign wr_idx = frame_restart ? '0 : wr_ptr;
   assign w_data = {data_in[R_LSB+8-BPC +: BPC],
                    data_in[G_LSB+8-BPC +: BPC],
                    data_in[B_LSB+8-BPC +: BPC]};
   assign unused_bits  = ^data_in;
   assign data_in_full = swap_pending;

   // Frame size is a power of two, so the pointer wraps by overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         swap_pending <= 1'b0;
         disp_bank    <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_idx + 1'b1;
            if (&wr_idx) swap_pending <= 1'b1;
         end else if (frame_restart) begin
            wr_ptr <= '0;
         end
         if (frame_end && swap_pending) begin
            disp_bank    <= ~disp_bank;
            swap_pending <= 1'b0;
         end
      end
   end

   // ---------------- scan FSM ----------------
   scan_state_e     state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt, disp_last;
   logic            hi, hi_nxt, rd_en;
   logic [CB-1:0]   col, col_nxt, rd_col;
   logic [PLW-1:0]  plane, plane_nxt;
   logic [RB-1:0]   row, row_nxt;
   rgb_bits_t [1:0] rd_bits;

   assign disp_last = (CW'(BASE_ON) << plane) - CW'(1);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 1'b1;
      hi_nxt    = hi;
      col_nxt   = col;
      plane_nxt = plane;
      row_nxt   = row;
      rd_en     = 1'b0;
      rd_col    = col;
      frame_end = 1'b0;
      case (state)
         ST_PREP: begin
            state_nxt = ST_SHIFT;
            cnt_nxt   = '0;
            hi_nxt    = 1'b0;
            col_nxt   = '0;
            rd_en     = 1'b1;
            rd_col    = '0;
         end
         ST_SHIFT: if (cnt == DIV_LAST) begin
            cnt_nxt = '0;
            hi_nxt  = ~hi;
            if (hi) begin
               if (col == COL_LAST) begin
                  state_nxt = ST_LATCH;
               end else begin
                  // Fetch the next column so it lands on its first low cycle.
                  col_nxt = col + 1'b1;
                  rd_en   = 1'b1;
                  rd_col  = col + 1'b1;
               end
            end
         end
         ST_LATCH: if (cnt == DIV_LAST) begin
            state_nxt = ST_DISPLAY;
            cnt_nxt   = '0;
         end
         ST_DISPLAY: if (cnt == disp_last) begin
            state_nxt = ST_PREP;
            cnt_nxt   = '0;
            if (plane == PLANE_LAST) begin
               plane_nxt = '0;
               row_nxt   = row + 1'b1;
               frame_end = (row == ROW_LAST);
            end else begin
               plane_nxt = plane + 1'b1;
            end
         end
         default: state_nxt = ST_PREP;
      endcase
   end

   // Panel controls are registered from next-state values so they align with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_PREP;
         cnt     <= '0;
         hi      <= 1'b0;
         col     <= '0;
         plane   <= '0;
         row     <= '0;
         led_clk <= 1'b0;
         lat     <= 1'b0;
         oeb     <= 1'b1;
         line    <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         hi      <= hi_nxt;
         col     <= col_nxt;
         plane   <= plane_nxt;
         row     <= row_nxt;
         led_clk <= (state_nxt == ST_SHIFT) && hi_nxt;
         lat     <= (state_nxt == ST_LATCH);
         oeb     <= (state_nxt != ST_DISPLAY);
         if (state_nxt == ST_LATCH) line <= row;
      end
   end

   hub75_frame_buf #(
      .COLS          (COLS),
      .ROW_ADDR_BITS (ROW_ADDR_BITS),
      .BPC           (BPC)
   ) u_fbuf (
      .clk     (clk),
      .reset   (reset),
      .we      (wr_ok),
      .w_half  (wr_idx[PW-1]),
      .w_addr  ({~disp_bank, wr_idx[PW-2:0]}),
      .w_data  (w_data),
      .re      (rd_en),
      .r_addr  ({disp_bank, row, rd_col}),
      .r_plane (plane),
      .rd_bits (rd_bits)
   );

   assign r1 = rd_bits[0].r;
   assign g1 = rd_bits[0].g;
   assign b1 = rd_bits[0].b;
   assign r2 = rd_bits[1].r;
   assign g2 = rd_bits[1].g;
   assign b2 = rd_bits[1].b;

endmodule

// File: tb/tb_hub75_bcm_ctrl.sv
// Directed bench for hub75_bcm_ctrl at COLS=4, ROW_ADDR_BITS=1, BPC=2, CLK_DIV=1, BASE_ON=2.
module tb_hub75_bcm_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data_in = '0;
   logic        data_in_en = 1'b0;
   logic        frame_restart = 1'b0;
   logic        data_in_full, led_clk, lat, oeb, r1, g1, b1, r2, g2, b2;
   logic [0:0]  line;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   logic [5:0] cap [16];

   hub75_bcm_ctrl #(
      .COLS(4), .ROW_ADDR_BITS(1), .BPC(2), .CLK_DIV(1), .BASE_ON(2)
   ) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_in_en(data_in_en),
      .data_in_full(data_in_full), .frame_restart(frame_restart),
      .led_clk(led_clk), .lat(lat), .oeb(oeb),
      .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2), .line(line)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic wr(input logic [31:0] d, input logic rs);
      data_in       = d;
      data_in_en    = 1'b1;
      frame_restart = rs;
      @(negedge clk);
      data_in_en    = 1'b0;
      frame_restart = 1'b0;
   endtask

   // Next DISPLAY window: start cycle, length in cycles, and line during it.
   task automatic disp_meas(output int t, output int len, output logic ln);
      logic ok = 1'b0;
      t = 0; len = 0; ln = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!oeb) begin ok = 1'b1; break; end
      end
      chk("disp_wait", {31'd0, ok}, 32'd1);
      t  = cyc;
      ln = line;
      while (!oeb && len < 600) begin
         len++;
         @(negedge clk);
      end
   endtask

   task automatic wait_swap();
      logic ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (!data_in_full) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("swap_wait", {31'd0, ok}, 32'd1);
   endtask

   // Colour bits {r1,g1,b1,r2,g2,b2} on each high led_clk cycle of one frame.
   task automatic capture();
      int n = 0;
      for (int i = 0; i < 80 && n < 16; i++) begin
         if (led_clk) begin
            cap[n] = {r1, g1, b1, r2, g2, b2};
            n++;
         end
         @(negedge clk);
      end
      chk("cap_edges", n, 16);
   endtask

   function automatic int count_eq(input logic [5:0] v);
      int n = 0;
      for (int i = 0; i < 16; i++) if (cap[i] == v) n++;
      return n;
   endfunction

   initial begin
      int t_rel, t0, t1, t2, t3, t4, l0, l1, l2, l3, l4;
      logic ln0, ln1, ln2, ln3, ln4;

      // reset state and scan timing
      repeat (3) @(negedge clk);
      chk("rst_oeb", oeb, 1);
      chk("rst_line", line, 0);
      chk("rst_lat", lat, 0);
      chk("rst_full", data_in_full, 0);
      chk("rst_ledclk", led_clk, 0);
      reset = 1'b0;
      t_rel = cyc;
      disp_meas(t0, l0, ln0);
      disp_meas(t1, l1, ln1);
      disp_meas(t2, l2, ln2);
      disp_meas(t3, l3, ln3);
      disp_meas(t4, l4, ln4);
      chk("first_disp_at", t0 - t_rel, 10);
      chk("p0_on_len", l0, 2);
      chk("p1_on_len", l1, 4);
      chk("row0_line", {31'd0, ln0}, 0);
      chk("row1_line", {31'd0, ln2}, 1);
      chk("frame_period", t4 - t0, 52);

      // full red frame
      for (int i = 0; i < 15; i++) wr(32'h00FF0000, 1'b0);
      chk("full_at15", data_in_full, 0);
      wr(32'h00FF0000, 1'b0);
      chk("full_at16", data_in_full, 1);
      wait_swap();
      capture();
      chk("red_all", count_eq(6'b100100), 16);

      // MSB-only red at pixel 0
      wr(32'h00800000, 1'b0);
      for (int i = 0; i < 15; i++) wr(32'h0, 1'b0);
      wait_swap();
      capture();
      chk("msb_plane0", cap[0], 6'b000000);
      chk("msb_plane1", cap[4], 6'b100000);
      chk("msb_rest", count_eq(6'b000000), 15);

      // write while full is dropped
      for (int i = 0; i < 16; i++) wr(32'h0000FF00, 1'b0);
      wr(32'h000000FF, 1'b0);
      chk("drop_full", data_in_full, 1);
      wait_swap();
      capture();
      chk("drop_green", count_eq(6'b010010), 16);

      // pointer still at 0 after the dropped word
      for (int i = 0; i < 15; i++) wr(32'h0, 1'b0);
      chk("ptr_full15", data_in_full, 0);
      wr(32'h0, 1'b0);
      chk("ptr_full16", data_in_full, 1);
      wait_swap();
      capture();
      chk("zero_frame", count_eq(6'b000000), 16);

      // frame restart with a blue word
      for (int i = 0; i < 5; i++) wr(32'h00FF0000, 1'b0);
      wr(32'h000000FF, 1'b1);
      for (int i = 0; i < 14; i++) wr(32'h0, 1'b0);
      chk("rs_full15", data_in_full, 0);
      wr(32'h0, 1'b0);
      chk("rs_full16", data_in_full, 1);
      wait_swap();
      capture();
      chk("rs_blue_p0", cap[0], 6'b001000);
      chk("rs_blue_p1", cap[4], 6'b001000);
      chk("rs_rest", count_eq(6'b000000), 14);

      // reset in the middle of a row-1 shift
      begin
         logic ok = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (led_clk && line == 1'b1) begin ok = 1'b1; break; end
         end
         chk("mid_shift_wait", {31'd0, ok}, 32'd1);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_oeb", oeb, 1);
      chk("mrst_ledclk", led_clk, 0);
      chk("mrst_line", line, 0);
      chk("mrst_lat", lat, 0);
      chk("mrst_colour", {r1, g1, b1, r2, g2, b2}, 0);
      reset = 1'b0;
      t_rel = cyc;
      disp_meas(t0, l0, ln0);
      chk("mrst_prep_restart", t0 - t_rel, 10);
      chk("mrst_p0_len", l0, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
